alu_seq: RTL and testbench

- Sequential 16-bit ALU for the FPG8 datapath. It sits directly upstream of the zero/negative comparator: its registered result drives the comparator input, and the condition-code latch consumes the comparator flags.
- Single-cycle ops complete in one clock. MUL is an iterative shift-add taking WIDTH clocks.
- Control talks to it through a start/busy/done handshake.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_seq_if.sv | 24 ++
 rtl/alu_mul_iter.sv | 44 ++++
 rtl/alu_seq.sv | 130 +++++++++++++
 tb/tb_alu_seq.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings, FSM states and default width.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 16;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOT   = 4'd5,
    OP_SHL   = 4'd6,
    OP_SHR   = 4'd7,
    OP_PASSA = 4'd8,
    OP_PASSB = 4'd9,
    OP_MUL   = 4'd10
  } op_e;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_e;

endpackage

// File: rtl/alu_seq_if.sv
// Start/busy/done request bus between control and the sequential ALU.
interface alu_seq_if #(
  parameter int unsigned WIDTH = alu_pkg::ALU_WIDTH
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             busy;
  logic             done;

  modport master (
    output start, op, operand_a, operand_b,
    input  result, carry_out, overflow, busy, done
  );

  modport slave (
    input  start, op, operand_a, operand_b,
    output result, carry_out, overflow, busy, done
  );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier datapath; one partial product per step, WIDTH steps total.
module alu_mul_iter #(
  parameter int unsigned WIDTH = alu_pkg::ALU_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product_c,
  output logic               last_c
);
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH);

  logic [PW-1:0]    mcand;
  logic [WIDTH-1:0] mplier;
  logic [PW-1:0]    acc;
  logic [CW-1:0]    count;

  // Accumulator value after the current step, exposed so the final step lands in the result.
  assign product_c = acc + (mplier[0] ? mcand : '0);
  assign last_c    = (count == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (load) begin
      mcand  <= PW'(a);
      mplier <= b;
      acc    <= '0;
      count  <= '0;
    end else if (step) begin
      acc    <= product_c;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= count + CW'(1);
    end
  end
endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: single-cycle ops registered on the start edge, MUL runs WIDTH cycles.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);
  state_e             state;
  logic [WIDTH-1:0]   result;
  logic               carry_out;
  logic               overflow;
  logic               busy;
  logic               done;

  logic [WIDTH:0]     sum_c;
  logic [WIDTH:0]     diff_c;
  logic [WIDTH-1:0]   res_c;
  logic               cy_c;
  logic               ov_c;
  logic               load_c;
  logic               step_c;
  logic [2*WIDTH-1:0] product_c;
  logic               last_c;

  assign sum_c  = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
  assign diff_c = {1'b0, bus.operand_a} - {1'b0, bus.operand_b};

  // Single-cycle op results and flags; undefined codes and MUL fall through to zero here.
  always_comb begin
    res_c = '0;
    cy_c  = 1'b0;
    ov_c  = 1'b0;
    case (bus.op)
      OP_ADD: begin
        res_c = sum_c[WIDTH-1:0];
        cy_c  = sum_c[WIDTH];
        ov_c  = (bus.operand_a[WIDTH-1] == bus.operand_b[WIDTH-1]) &&
                (sum_c[WIDTH-1] != bus.operand_a[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = diff_c[WIDTH-1:0];
        cy_c  = diff_c[WIDTH];
        ov_c  = (bus.operand_a[WIDTH-1] != bus.operand_b[WIDTH-1]) &&
                (diff_c[WIDTH-1] != bus.operand_a[WIDTH-1]);
      end
      OP_AND:   res_c = bus.operand_a & bus.operand_b;
      OP_OR:    res_c = bus.operand_a | bus.operand_b;
      OP_XOR:   res_c = bus.operand_a ^ bus.operand_b;
      OP_NOT:   res_c = ~bus.operand_a;
      OP_SHL: begin
        res_c = {bus.operand_a[WIDTH-2:0], 1'b0};
        cy_c  = bus.operand_a[WIDTH-1];
      end
      OP_SHR: begin
        res_c = {1'b0, bus.operand_a[WIDTH-1:1]};
        cy_c  = bus.operand_a[0];
      end
      OP_PASSA: res_c = bus.operand_a;
      OP_PASSB: res_c = bus.operand_b;
      default: begin
        res_c = '0;
        cy_c  = 1'b0;
        ov_c  = 1'b0;
      end
    endcase
  end

  assign load_c = (state == IDLE) && bus.start && (bus.op == OP_MUL);
  assign step_c = (state == MUL);

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .load      (load_c),
    .step      (step_c),
    .a         (bus.operand_a),
    .b         (bus.operand_b),
    .product_c (product_c),
    .last_c    (last_c)
  );

  // Control FSM with registered result, flags and handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.op == OP_MUL) begin
              busy  <= 1'b1;
              state <= MUL;
            end else begin
              result    <= res_c;
              carry_out <= cy_c;
              overflow  <= ov_c;
              done      <= 1'b1;
            end
          end
        end
        MUL: begin
          if (last_c) begin
            result    <= product_c[WIDTH-1:0];
            carry_out <= |product_c[2*WIDTH-1:WIDTH];
            overflow  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.result    = result;
  assign bus.carry_out = carry_out;
  assign bus.overflow  = overflow;
  assign bus.busy      = busy;
  assign bus.done      = done;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq with hand-computed expected values.
module tb_alu_seq;
  import alu_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  alu_seq_if #(.WIDTH(16)) bus ();

  alu_seq #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request for exactly one edge, then sample #1 after that edge.
  task automatic issue(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    bus.start     = 1'b1;
    bus.op        = op;
    bus.operand_a = a;
    bus.operand_b = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [15:0] res, input logic cy,
                           input logic ov, input logic dn);
    check_eq({tag, ".result"}, 32'(bus.result), 32'(res));
    check_eq({tag, ".carry"}, 32'(bus.carry_out), 32'(cy));
    check_eq({tag, ".ovf"}, 32'(bus.overflow), 32'(ov));
    check_eq({tag, ".done"}, 32'(bus.done), 32'(dn));
  endtask

  // Wait for done with a cycle budget; returns cycles elapsed (budget+1 on timeout).
  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (bus.done !== 1'b1 && cycles <= budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  logic [3:0]  tbl_op  [6];
  logic [15:0] tbl_exp [6];

  initial begin
    int cyc;
    int spurious;
    n_cmp = 0;
    n_err = 0;
    bus.start     = 1'b0;
    bus.op        = 4'd0;
    bus.operand_a = '0;
    bus.operand_b = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
    check_eq("reset.busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // ADD overflow, then done drops and result holds
    issue(OP_ADD, 16'h7FFF, 16'h0001);
    check_out("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    check_out("add_hold", 16'h8000, 1'b0, 1'b1, 1'b0);

    issue(OP_ADD, 16'hFFFF, 16'h0001);
    check_out("add_carry", 16'h0000, 1'b1, 1'b0, 1'b1);

    // Logic and pass ops clear flags
    tbl_op[0] = OP_AND;   tbl_exp[0] = 16'h3030;
    tbl_op[1] = OP_OR;    tbl_exp[1] = 16'hFCFC;
    tbl_op[2] = OP_XOR;   tbl_exp[2] = 16'hCCCC;
    tbl_op[3] = OP_NOT;   tbl_exp[3] = 16'h0F0F;
    tbl_op[4] = OP_PASSA; tbl_exp[4] = 16'hF0F0;
    tbl_op[5] = OP_PASSB; tbl_exp[5] = 16'h3C3C;
    for (int i = 0; i < 6; i++) begin
      issue(tbl_op[i], 16'hF0F0, 16'h3C3C);
      check_out($sformatf("logic%0d", i), tbl_exp[i], 1'b0, 1'b0, 1'b1);
    end

    issue(OP_SUB, 16'h0003, 16'h0005);
    check_out("sub_borrow", 16'hFFFE, 1'b1, 1'b0, 1'b1);
    issue(OP_SUB, 16'h8000, 16'h0001);
    check_out("sub_ovf", 16'h7FFF, 1'b0, 1'b1, 1'b1);

    // MUL with ignored starts and operand changes while busy
    issue(OP_MUL, 16'h0123, 16'h0045);
    check_eq("mul0.busy_start", 32'(bus.busy), 32'd1);
    check_eq("mul0.done_start", 32'(bus.done), 32'd0);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      if (i == 3 || i == 8) begin
        bus.start     = 1'b1;
        bus.op        = OP_ADD;
        bus.operand_a = 16'h0001;
        bus.operand_b = 16'h0001;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (i < 16) begin
        check_eq($sformatf("mul0.busy%0d", i), 32'(bus.busy), 32'd1);
        check_eq($sformatf("mul0.done%0d", i), 32'(bus.done), 32'd0);
      end
    end
    bus.start = 1'b0;
    check_out("mul0", 16'h4E6F, 1'b0, 1'b0, 1'b1);
    check_eq("mul0.busy_end", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    check_out("mul0_noqueue", 16'h4E6F, 1'b0, 1'b0, 1'b0);

    issue(OP_MUL, 16'h1000, 16'h0010);
    wait_done(20, cyc);
    check_eq("mul1.latency", 32'(cyc), 32'd16);
    check_out("mul1", 16'h0000, 1'b1, 1'b0, 1'b1);

    // Back-to-back shifts: two consecutive done pulses
    issue(OP_SHL, 16'h8001, 16'h0000);
    check_out("shl", 16'h0002, 1'b1, 1'b0, 1'b1);
    issue(OP_SHR, 16'h8001, 16'h0000);
    check_out("shr", 16'h4000, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_eq("shr.done_drop", 32'(bus.done), 32'd0);

    // Async reset in the middle of a multiply
    issue(OP_MUL, 16'h0123, 16'h0045);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_out("rst_mid", 16'h0000, 1'b0, 1'b0, 1'b0);
    check_eq("rst_mid.busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    issue(OP_ADD, 16'h0001, 16'h0001);
    check_out("post_rst_add", 16'h0002, 1'b0, 1'b0, 1'b1);
    spurious = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) spurious++;
    end
    check_eq("post_rst_quiet", 32'(spurious), 32'd0);

    // Undefined opcode zeroes result and flags, still pulses done once
    issue(OP_SHL, 16'h8001, 16'h0000);
    issue(4'd13, 16'hFFFF, 16'h1234);
    check_out("undef", 16'h0000, 1'b0, 1'b0, 1'b1);
    @(posedge clk); #1;
    check_eq("undef.done_drop", 32'(bus.done), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
